fp_sqrt_iter: RTL and testbench

Iterative fixed-point square-root unit for the math primitive library. It is the parametrised successor of the single-bit-per-cycle sqrt. The unroll factor (root bits resolved per clock) is configurable, and round-to-nearest is selectable per operation. The exact remainder is exposed, and the unit has an explicit busy/done handshake with synchronous active-low reset. It sits behind Calyx `go`/`done` invocation as a multi-cycle math cell; integer sqrt is the `FRAC_WIDTH = 0` instance.

---
 rtl/fp_sqrt_iter.sv | 96 +++++++++
 tb/tb_fp_sqrt_iter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: iterative restoring fixed-point square root with selectable rounding and exact remainder
module fp_sqrt_iter #(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 16,
  parameter int UNROLL     = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            go,
  input  logic                            round,
  input  logic [WIDTH-1:0]                in,
  output logic [WIDTH-1:0]                out,
  output logic [(WIDTH+FRAC_WIDTH)/2:0]   rem,
  output logic                            busy,
  output logic                            done
);
  localparam int ROOT_W = (WIDTH + FRAC_WIDTH) / 2;
  localparam int N      = ROOT_W / UNROLL;
  localparam int CW     = $clog2(N + 1);
  if ((WIDTH + FRAC_WIDTH) % 2 != 0 || FRAC_WIDTH >= WIDTH || ROOT_W % UNROLL != 0) begin : g_param_err
    $error("fp_sqrt_iter: illegal WIDTH/FRAC_WIDTH/UNROLL combination");
  end
  typedef enum logic [1:0] {IDLE, RUN, ROUND} state_t;
  state_t                state, state_n;
  logic [2*ROOT_W-1:0]   rad, rad_n;
  logic [ROOT_W+1:0]     acc, acc_n;
  logic [ROOT_W-1:0]     q, q_n;
  logic [ROOT_W+2:0]     diff;
  logic [CW-1:0]         cnt;
  logic                  rnd;
  logic [WIDTH:0]        q_inc;
  assign busy  = state != IDLE;
  assign q_inc = {1'b0, WIDTH'(q)} + (WIDTH+1)'(rnd && acc > {2'b00, q});
  always_comb begin
    acc_n = acc;
    q_n   = q;
    rad_n = rad;
    diff  = '0;
    for (int i = 0; i < UNROLL; i++) begin
      acc_n = {acc_n[ROOT_W-1:0], rad_n[2*ROOT_W-1 -: 2]};
      rad_n = rad_n << 2;
      diff  = {1'b0, acc_n} - {1'b0, q_n, 2'b01};
      acc_n = diff[ROOT_W+2] ? acc_n : diff[ROOT_W+1:0];
      q_n   = {q_n[ROOT_W-2:0], ~diff[ROOT_W+2]};
    end
  end
  always_comb begin
    state_n = state == IDLE ? (go ? RUN : IDLE)
            : state == RUN  ? (cnt == CW'(N - 1) ? ROUND : RUN)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rad   <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      rnd   <= 1'b0;
      out   <= '0;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= state == ROUND;
      if (state == IDLE && go) begin
        rad <= (2*ROOT_W)'(in) << FRAC_WIDTH;
        acc <= '0;
        q   <= '0;
        cnt <= '0;
        rnd <= round;
      end
      if (state == RUN) begin
        rad <= rad_n;
        acc <= acc_n;
        q   <= q_n;
        cnt <= cnt + CW'(1);
      end
      if (state == ROUND) begin
        out <= q_inc[WIDTH] ? '1 : q_inc[WIDTH-1:0];
        rem <= acc[ROOT_W:0];
      end
    end
  end
  logic [WIDTH-1:0]     in_s;
  logic [2*WIDTH+1:0]   chk_r, chk_q;
  assign chk_r = (2*WIDTH+2)'(in_s) << FRAC_WIDTH;
  assign chk_q = (2*WIDTH+2)'(out);
  always_ff @(posedge clk) begin
    if (state == IDLE && go) in_s <= in;
  end
  always_ff @(posedge clk) begin
    if (reset && done && !rnd && (chk_q * chk_q > chk_r || (chk_q + 1) * (chk_q + 1) <= chk_r))
      $error("fp_sqrt_iter: root 0x%0h wrong for input 0x%0h", out, in_s);
  end
endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb_fp_sqrt_iter: scoreboard bench running several fp_sqrt_iter configurations against an arithmetic model
module tb_fp_sqrt_iter;
  typedef struct {
    logic [31:0] out;
    longint      rem;
    longint      q;
    longint      go_cyc;
  } exp_t;
  logic        clk = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] dirv [7] = '{32'h0002_0000, 32'hFFFF_FFFF, 32'd16, 32'd0, 32'd1, 32'h0001_0000, 32'h7FFF_FFFF};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input int g, input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", g, nm, got, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic [31:0] v, input bit r, input int fr, input int c);
    exp_t   e;
    longint rr = longint'(v) << fr;
    longint q  = longint'($floor($sqrt(real'(rr))));
    while (q * q > rr) q--;
    while ((q + 1) * (q + 1) <= rr) q++;
    e.q      = q;
    e.rem    = rr - q * q;
    e.out    = 32'((r && e.rem > q) ? q + 1 : q);
    e.go_cyc = c;
    return e;
  endfunction
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int FR = (g % 2 == 0) ? 16 : 0;
    localparam int UN = g == 0 ? 1 : g == 1 ? 4 : g == 2 ? 8 : 2;
    localparam int RW = (32 + FR) / 2;
    localparam int N  = RW / UN;
    logic          reset = 1'b0, go = 1'b0, rnd = 1'b0, busy, done;
    logic [31:0]   din = '0, out;
    logic [RW:0]   rem;
    logic [RW+32:0] held = '0;
    bit            fin = 1'b0;
    exp_t          sb[$];
    fp_sqrt_iter #(.WIDTH(32), .FRAC_WIDTH(FR), .UNROLL(UN)) dut (
      .clk(clk), .reset(reset), .go(go), .round(rnd), .in(din),
      .out(out), .rem(rem), .busy(busy), .done(done)
    );
    always @(negedge clk) begin
      exp_t e;
      if (busy === 1'b1) chk(g, "out_hold", longint'({out, rem}), longint'(held));
      else held <= {out, rem};
      if (done === 1'b1) begin
        if (sb.size() == 0) chk(g, "spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk(g, "out", longint'(out), longint'(e.out));
          chk(g, "rem", longint'(rem), e.rem);
          chk(g, "rem_bound", longint'(longint'(rem) <= 2 * e.q), 1);
          chk(g, "latency", longint'(cyc) - e.go_cyc, N + 2);
          chk(g, "busy_at_done", longint'(busy), 0);
        end
      end
    end
    task automatic issue(input logic [31:0] v, input bit r, input bit push);
      @(negedge clk);
      din = v;
      rnd = r;
      go  = 1'b1;
      if (push) sb.push_back(model(v, r, FR, cyc));
      @(negedge clk);
      go  = 1'b0;
      din = $urandom;
      rnd = 1'($urandom_range(0, 1));
      chk(g, "busy_run", longint'(busy), 1);
    endtask
    task automatic wait_idle();
      int k = 0;
      while ((busy !== 1'b0 || sb.size() != 0) && k < 4 * N + 40) begin
        @(negedge clk);
        k++;
      end
      chk(g, "idle_wait_expired", longint'(k >= 4 * N + 40), 0);
    endtask
    initial begin
      int c;
      go  = 1'b1;
      din = 32'h1234_5678;
      repeat (3) @(negedge clk);
      chk(g, "rst_out", longint'(out), 0);
      chk(g, "rst_rem", longint'(rem), 0);
      chk(g, "rst_busy", longint'(busy), 0);
      chk(g, "rst_done", longint'(done), 0);
      go    = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 7; i++)
        for (int r = 0; r < 2; r++) begin
          wait_idle();
          issue(dirv[i], r[0], 1'b1);
        end
      wait_idle();
      issue(32'h0000_4000, 1'b0, 1'b1);
      @(negedge clk);
      din = 32'h0909_0909;
      go  = 1'b1;
      @(negedge clk);
      go  = 1'b0;
      wait_idle();
      issue(32'h0003_0000, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk(g, "abort_out", longint'(out), 0);
      chk(g, "abort_rem", longint'(rem), 0);
      chk(g, "abort_busy", longint'(busy), 0);
      repeat (N + 4) @(negedge clk);
      wait_idle();
      issue(32'h0003_0000, 1'b1, 1'b1);
      wait_idle();
      @(negedge clk);
      c   = cyc;
      din = 32'h00C0_FFEE;
      rnd = 1'b1;
      go  = 1'b1;
      for (int j = 0; j < 3; j++) begin
        sb.push_back(model(32'h00C0_FFEE, 1'b1, FR, c + j * (N + 2)));
        if (j < 2) repeat (N + 2) @(negedge clk);
      end
      @(negedge clk);
      go = 1'b0;
      wait_idle();
      for (int i = 0; i < 800; i++) begin
        wait_idle();
        issue($urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 300)) : $urandom, 1'($urandom_range(0, 1)), 1'b1);
      end
      wait_idle();
      fin = 1'b1;
    end
  end
  initial begin
    int k = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && k < 90000) begin
      @(negedge clk);
      k++;
    end
    chk(-1, "global_timeout", longint'(k >= 90000), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
